// File: rtl/cpu_pkg.sv
// Shared processor types: fetch-stage state encoding, next-PC select codes and
// the architectural PC/instruction widths.
package cpu_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned PC_W    = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_ADV,
    SEL_REDIR,
    SEL_HALT
  } pc_sel_t;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection for the fetch stage: halt > redirect > advance > hold,
// relative-target adder with offset sign extension, and PC wrap detection.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned D     = PC_W,
  parameter int unsigned OFS_W = 8
) (
  input  logic [D-1:0]     i_pc,
  input  logic             i_run,
  input  logic             i_halt_req,
  input  logic             i_redirect_en,
  input  logic             i_redirect_rel,
  input  logic [D-1:0]     i_redirect_target,
  input  logic [D-1:0]     i_redirect_base,
  input  logic [OFS_W-1:0] i_redirect_ofs,
  input  logic             i_instr_valid,
  input  logic             i_instr_ready,
  output pc_sel_t          o_sel,
  output logic [D-1:0]     o_next_pc,
  output logic             o_wrap
);

  logic [D-1:0] w_ofs_ext;
  logic [D-1:0] w_rel_target;
  logic [D-1:0] w_inc;

  // D must exceed OFS_W; the sum is taken modulo 2**D by truncation.
  assign w_ofs_ext    = {{(D-OFS_W){i_redirect_ofs[OFS_W-1]}}, i_redirect_ofs};
  assign w_rel_target = i_redirect_base + w_ofs_ext;
  assign w_inc        = i_pc + D'(1);

  always_comb begin
    o_sel     = SEL_HOLD;
    o_next_pc = i_pc;
    o_wrap    = 1'b0;
    if (i_run) begin
      if (i_halt_req) begin
        o_sel = SEL_HALT;
      end else if (i_redirect_en) begin
        o_sel     = SEL_REDIR;
        o_next_pc = i_redirect_rel ? w_rel_target : i_redirect_target;
      end else if (!i_instr_valid || i_instr_ready) begin
        o_sel     = SEL_ADV;
        o_next_pc = w_inc;
        o_wrap    = &i_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational ROM and registers the
// returned machine code for decode behind a valid/ready handshake.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned D     = PC_W,
  parameter int unsigned IW    = INSTR_W,
  parameter int unsigned OFS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [D-1:0]     start_addr,
  output logic [D-1:0]     programCounter,
  input  logic [IW-1:0]    machineCode,
  output logic [IW-1:0]    instr,
  output logic [D-1:0]     instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect_en,
  input  logic             redirect_rel,
  input  logic [D-1:0]     redirect_target,
  input  logic [D-1:0]     redirect_base,
  input  logic [OFS_W-1:0] redirect_ofs,
  input  logic             halt_req,
  output logic             done,
  output logic             wrap_flag
);

  fetch_state_t r_state;
  logic [D-1:0]  r_pc;
  logic [D-1:0]  r_instr_pc;
  logic [IW-1:0] r_instr;
  logic          r_valid;
  logic          r_done;
  logic          r_wrap;

  pc_sel_t      w_sel;
  logic [D-1:0] w_next_pc;
  logic         w_wrap;

  pc_next_calc #(
    .D     (D),
    .OFS_W (OFS_W)
  ) u_pc_next (
    .i_pc              (r_pc),
    .i_run             (r_state == RUN),
    .i_halt_req        (halt_req),
    .i_redirect_en     (redirect_en),
    .i_redirect_rel    (redirect_rel),
    .i_redirect_target (redirect_target),
    .i_redirect_base   (redirect_base),
    .i_redirect_ofs    (redirect_ofs),
    .i_instr_valid     (r_valid),
    .i_instr_ready     (instr_ready),
    .o_sel             (w_sel),
    .o_next_pc         (w_next_pc),
    .o_wrap            (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pc    <= start_addr;
            r_wrap  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          case (w_sel)
            SEL_HALT: begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= HALTED;
            end
            // A redirect discards the presented instruction even if decode is ready.
            SEL_REDIR: begin
              r_pc    <= w_next_pc;
              r_valid <= 1'b0;
            end
            SEL_ADV: begin
              r_instr    <= machineCode;
              r_instr_pc <= r_pc;
              r_valid    <= 1'b1;
              r_pc       <= w_next_pc;
              if (w_wrap) begin
                r_wrap <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
        HALTED: begin
          if (start) begin
            r_pc    <= start_addr;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign programCounter = r_pc;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_valid;
  assign done           = r_done;
  assign wrap_flag      = r_wrap;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the program-order start address
// of each new instruction stream; a negedge monitor checks every cycle against it.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int D     = 12;
  localparam int IW    = 9;
  localparam int OFS_W = 8;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n, start, instr_ready, redirect_en, redirect_rel, halt_req;
  pc_t  start_addr, programCounter, instr_pc, redirect_target, redirect_base;
  instr_t machineCode, instr;
  logic [OFS_W-1:0] redirect_ofs;
  logic instr_valid, done, wrap_flag;

  instr_t rom [DEPTH];
  int n_checks = 0;
  int n_errors = 0;
  int q_target[$];

  typedef enum {S_IDLE, S_RUN, S_HALT} s_state_e;
  s_state_e s_st = S_IDLE;
  s_state_e m_st = S_IDLE;
  int m_exp = 0;
  int m_since = 0;
  int m_frozen = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;
  assign machineCode = rom[programCounter];

  fetch_unit #(.D(D), .IW(IW), .OFS_W(OFS_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .start_addr      (start_addr),
    .programCounter  (programCounter),
    .machineCode     (machineCode),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_en     (redirect_en),
    .redirect_rel    (redirect_rel),
    .redirect_target (redirect_target),
    .redirect_base   (redirect_base),
    .redirect_ofs    (redirect_ofs),
    .halt_req        (halt_req),
    .done            (done),
    .wrap_flag       (wrap_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rel_target(input int base, input int ofs8);
    int s;
    s = (ofs8 >= 128) ? ofs8 - 256 : ofs8;
    return (base + s + DEPTH) % DEPTH;
  endfunction

  function automatic int pop_target();
    if (q_target.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_underflow: got empty queue expected a target at %0t", $time);
      return 0;
    end
    return q_target.pop_front();
  endfunction

  // Monitor: model says an instruction stream starting at m_exp shows a one-cycle
  // bubble, then presents m_exp, m_exp+1, ... advancing only on accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_st   = S_IDLE;
      m_wrap = 1'b0;
      chk("rst_valid",   32'(instr_valid),    0);
      chk("rst_done",    32'(done),           0);
      chk("rst_wrap",    32'(wrap_flag),      0);
      chk("rst_pc",      32'(programCounter), 0);
      chk("rst_instr",   32'(instr),          0);
      chk("rst_instrpc", 32'(instr_pc),       0);
    end else begin
      if (m_st == S_RUN && m_since < 2) m_since++;
      case (m_st)
        S_IDLE: begin
          chk("idle_valid", 32'(instr_valid),    0);
          chk("idle_done",  32'(done),           0);
          chk("idle_pc",    32'(programCounter), 0);
          chk("idle_wrap",  32'(wrap_flag),      0);
        end
        S_RUN: begin
          if (m_since >= 2 && m_exp == DEPTH - 1) m_wrap = 1'b1;
          chk("run_valid", 32'(instr_valid), 32'(m_since >= 2));
          chk("run_done",  32'(done), 0);
          chk("run_wrap",  32'(wrap_flag), 32'(m_wrap));
          chk("run_pc",    32'(programCounter), (m_since >= 2) ? (m_exp + 1) % DEPTH : m_exp);
          if (m_since >= 2) begin
            chk("run_instrpc", 32'(instr_pc), m_exp);
            chk("run_instr",   32'(instr),    32'(rom[m_exp]));
          end
        end
        default: begin
          chk("halt_done",  32'(done),           1);
          chk("halt_valid", 32'(instr_valid),    0);
          chk("halt_pc",    32'(programCounter), m_frozen);
          chk("halt_wrap",  32'(wrap_flag),      32'(m_wrap));
        end
      endcase

      if (m_st == S_RUN) begin
        if (halt_req) begin
          m_frozen = (m_since >= 2) ? (m_exp + 1) % DEPTH : m_exp;
          m_st = S_HALT;
        end else if (redirect_en) begin
          m_exp   = pop_target();
          m_since = 0;
        end else if (m_since >= 2 && instr_ready) begin
          m_exp = (m_exp + 1) % DEPTH;
        end
      end else if (start) begin
        m_exp   = pop_target();
        m_since = 0;
        m_wrap  = 1'b0;
        m_st    = S_RUN;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start       = 1'b0;
    redirect_en = 1'b0;
    halt_req    = 1'b0;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      instr_ready = rdy;
      tick();
    end
  endtask

  task automatic do_start(input int a);
    start      = 1'b1;
    start_addr = D'(a);
    q_target.push_back(a);
    s_st = S_RUN;
    tick();
  endtask

  task automatic do_redir(input bit rel, input int tgt, input int base, input int ofs);
    redirect_en     = 1'b1;
    redirect_rel    = rel;
    redirect_target = D'(tgt);
    redirect_base   = D'(base);
    redirect_ofs    = OFS_W'(ofs);
    q_target.push_back(rel ? rel_target(base, ofs) : tgt);
    tick();
  endtask

  task automatic do_halt(input bit with_redir);
    halt_req        = 1'b1;
    redirect_en     = with_redir;
    redirect_rel    = 1'b0;
    redirect_target = D'($urandom);
    s_st = S_HALT;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_st  = S_IDLE;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return DEPTH - 1 - int'($urandom_range(0, 15));
    return int'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    int r;
    foreach (rom[i]) rom[i] = IW'($urandom);
    rom[0] = 9'h07E;
    rom[1] = 9'h066;
    rom[2] = 9'h07A;
    rom[3] = 9'h1DE;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
    redirect_en = 1'b0; redirect_rel = 1'b0; redirect_target = '0;
    redirect_base = '0; redirect_ofs = '0; halt_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // start at 0, stream 0..3 with a three-cycle stall while instr_pc=2
    instr_ready = 1'b1;
    do_start(0);
    run(3, 1'b1);
    run(3, 1'b0);
    run(3, 1'b1);
    // absolute redirect while decode stalls
    instr_ready = 1'b0;
    do_redir(1'b0, 'h100, 'h3A5, 'h7F);
    run(1, 1'b0);
    run(3, 1'b1);
    // relative redirects, second one walks through the wrap
    instr_ready = 1'b1;
    do_redir(1'b1, 'h777, 'h005, 'hFD);
    run(4, 1'b1);
    do_redir(1'b1, 'h777, 'h001, 'hFC);
    run(6, 1'b1);
    // start during RUN is ignored
    start = 1'b1;
    start_addr = 'h555;
    tick();
    run(2, 1'b1);
    // halt wins over a simultaneous redirect, then restart
    do_halt(1'b1);
    run(3, 1'b1);
    do_start('h010);
    run(4, 1'b1);
    do_halt(1'b0);
    run(2, 1'b0);
    do_start('hFFE);
    run(5, 1'b1);
    do_reset();
    run(2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 999));
      if (s_st != S_RUN) begin
        if (r < 300) do_start(rand_addr());
        else tick();
      end else if (r < 10) begin
        do_halt(r < 4);
      end else if (r < 70) begin
        if (r < 40) do_redir(1'b0, rand_addr(), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
        else do_redir(1'b1, int'($urandom_range(0, DEPTH - 1)), rand_addr(), int'($urandom_range(0, 255)));
      end else if (r < 72) begin
        do_reset();
      end else begin
        tick();
      end
    end

    run(2, 1'b1);
    chk("queue_drained", 32'(q_target.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
